// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   - state_t        : loader FSM state encodings
//   - LEN_BYTES      : bytes in the little-endian word-count header
//   - BYTES_PER_WORD : bytes per instruction word
//   - len_overflow() : true when a header word count exceeds memory capacity
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the S_CSUM state).

package imem_loader_pkg;

    localparam int LEN_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM = 3'd2,
`endif
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // A count of exactly 2^addr_w words still fits; only larger counts fail.
    function automatic logic len_overflow(input logic [31:0] n, input int addr_w);
        logic [32:0] limit;
        limit = 33'd1 << addr_w;
        return ({1'b0, n} > limit);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer
// Assembles a byte stream into little-endian 32-bit words.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   byte_valid        : a byte is being accepted this cycle
//   byte_data [7:0]   : the byte
//   word [31:0]       : assembled word; valid together with word_valid
//   word_valid        : high for the single cycle in which the 4th byte of a
//                       word is accepted
// The first three bytes of a word are held in lane registers; the 4th byte is
// passed straight through to word[31:24] so the consumer can act on a complete
// word in the same cycle the last byte is accepted.

import imem_loader_pkg::*;

module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0] pos_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_reg <= 2'd0;
        end else if (byte_valid) begin
            pos_reg <= pos_reg + 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg <= 8'd0;
                end else if (byte_valid && (pos_reg == 2'(gi))) begin
                    lane_reg <= byte_data;
                end
            end

            assign word[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign word[31:24] = byte_data;
    assign word_valid  = byte_valid && (pos_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot-time loader: receives a program image as a byte stream, packs it into
// little-endian words, writes them sequentially into instruction memory and
// holds the CPU in reset until the image is complete.
// Image: 4-byte LE word count N, then N*4 payload bytes, then (checksum build
// only) one byte equal to the modulo-256 sum of the payload bytes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   rx_data, rx_valid        : incoming image byte stream
//   rx_ready                 : loader can accept a byte (registered)
//   imem_we/waddr/wdata      : registered one-cycle write per word
//   cpu_rst                  : CPU reset, released one cycle after S_RUN
//   load_done, load_err      : registered completion / sticky error flags

import imem_loader_pkg::*;

module imem_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    logic        accept;
    logic [31:0] word;
    logic        word_valid;

    state_t          state_reg;
    logic [ADDR_W:0] word_cnt_reg;
    logic [ADDR_W:0] len_reg;
    logic [ADDR_W:0] word_cnt_inc;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum_reg;
`endif

    assign accept       = rx_valid && rx_ready;
    assign word_cnt_inc = word_cnt_reg + 1'b1;

    // One packer serves both the length header and the payload: the header is
    // exactly one word, so the byte position is back at 0 when payload starts.
    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept),
        .byte_data  (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_LEN;
            word_cnt_reg <= '0;
            len_reg      <= '0;
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= 8'd0;
`endif
        end else begin
            imem_we   <= 1'b0;
            // Status flags follow the current state, so cpu_rst releases one
            // cycle after S_RUN is entered, after the final word's write edge.
            cpu_rst   <= (state_reg != S_RUN);
            load_done <= (state_reg == S_RUN);
            load_err  <= (state_reg == S_ERR);
            // Ready stays high in the collecting states; transitions into a
            // terminal state below override it so no extra byte is accepted.
            rx_ready  <= (state_reg != S_RUN) && (state_reg != S_ERR);

            case (state_reg)
                S_LEN: begin
                    if (word_valid) begin
                        word_cnt_reg <= '0;
                        if (len_overflow(word, ADDR_W)) begin
                            state_reg <= S_ERR;
                            rx_ready  <= 1'b0;
                        end else if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_reg <= S_CSUM;
`else
                            state_reg <= S_RUN;
                            rx_ready  <= 1'b0;
`endif
                        end else begin
                            len_reg   <= word[ADDR_W:0];
                            state_reg <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) begin
                        csum_reg <= csum_reg + rx_data;
                    end
`endif
                    if (word_valid) begin
                        imem_we      <= 1'b1;
                        imem_waddr   <= word_cnt_reg[ADDR_W-1:0];
                        imem_wdata   <= word;
                        word_cnt_reg <= word_cnt_inc;
                        if (word_cnt_inc == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_reg <= S_CSUM;
`else
                            state_reg <= S_RUN;
                            rx_ready  <= 1'b0;
`endif
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        rx_ready  <= 1'b0;
                        state_reg <= (rx_data == csum_reg) ? S_RUN : S_ERR;
                    end
                end
`endif

                S_RUN, S_ERR: begin
                    state_reg <= state_reg;
                end

                default: begin
                    state_reg <= S_ERR;
                    rx_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader with hand-computed expected words, addresses
// and status flags. Instruction memory is modelled here from the write port.
// Builds with or without IMEM_LOADER_CHECKSUM_EN.

module tb_imem_loader;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int base;
    logic [31:0] mem_model [0:15];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) begin
            wr_cnt <= wr_cnt + 1;
            if (imem_waddr < 16)
                mem_model[imem_waddr[3:0]] <= imem_wdata;
            $display("write addr=%0d data=%08h", imem_waddr, imem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and return #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 20) begin
            tick();
            t++;
        end
        if (!rx_ready) check("ready_wait", 32'(rx_ready), 32'd1);
        tick();
        rx_valid = 1'b0;
        $display("byte %02h accepted", b);
    endtask

    // Same as send_byte but with 0..2 idle cycles first.
    task automatic send_gap(input logic [7:0] b);
        int n;
        n = int'($urandom_range(0, 2));
        rx_valid = 1'b0;
        repeat (n) tick();
        send_byte(b);
    endtask

    task automatic send_len(input logic [31:0] n);
        logic [31:0] v;
        v = n;
        for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
    endtask

    // Checksum byte, only present in the checksum build.
    task automatic end_image(input logic [7:0] csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum);
`else
        if (csum == 8'hxx) $display("unused");
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(rx_ready), 32'd1);
    endtask

    // Checks made right after the edge that moved the FSM to S_RUN.
    task automatic expect_run(input string tag);
        check({tag, "_ready0"}, 32'(rx_ready), 32'd0);
        check({tag, "_cpu_rst_hold"}, 32'(cpu_rst), 32'd1);
        tick();
        check({tag, "_cpu_rst_low"}, 32'(cpu_rst), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd1);
        check({tag, "_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        logic [7:0] pay_a [0:7];
        logic [7:0] pay_g [0:7];
        pay_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        pay_g = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        tick();
        check("first_ready", 32'(rx_ready), 32'd1);

        // N=2 back-to-back
        base = wr_cnt;
        send_len(32'd2);
        for (int i = 0; i < 8; i++) begin
            send_byte(pay_a[i]);
            if (i == 2) check("a_no_we_early", 32'(imem_we), 32'd0);
            if (i == 3) begin
                check("a_we0", 32'(imem_we), 32'd1);
                check("a_waddr0", 32'(imem_waddr), 32'd0);
                check("a_wdata0", imem_wdata, 32'h44332211);
            end
            if (i == 4) check("a_we_one_cycle", 32'(imem_we), 32'd0);
            if (i == 7) begin
                check("a_we1", 32'(imem_we), 32'd1);
                check("a_waddr1", 32'(imem_waddr), 32'd1);
                check("a_wdata1", imem_wdata, 32'h88776655);
            end
        end
        end_image(8'h64);
        expect_run("a");
        check("a_mem0", mem_model[0], 32'h44332211);
        check("a_mem1", mem_model[1], 32'h88776655);
        check("a_wr_count", 32'(wr_cnt - base), 32'd2);
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        repeat (3) tick();
        rx_valid = 1'b0;
        check("a_run_ready0", 32'(rx_ready), 32'd0);
        check("a_run_no_wr", 32'(wr_cnt - base), 32'd2);
        check("a_run_cpu_rst", 32'(cpu_rst), 32'd0);

        // N=0
        do_reset();
        base = wr_cnt;
        send_len(32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("z_csum_ready", 32'(rx_ready), 32'd1);
`endif
        end_image(8'h00);
        expect_run("z");
        tick();
        check("z_no_write", 32'(wr_cnt - base), 32'd0);

        // N = 2^ADDR_W: largest legal count, must not error
        do_reset();
        send_len(32'h0001_0000);
        tick();
        check("max_err0", 32'(load_err), 32'd0);
        check("max_ready", 32'(rx_ready), 32'd1);

        // N = 2^ADDR_W + 1: overflow
        do_reset();
        base = wr_cnt;
        send_len(32'h0001_0001);
        check("ovf_ready0", 32'(rx_ready), 32'd0);
        tick();
        check("ovf_err", 32'(load_err), 32'd1);
        check("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (6) tick();
        rx_valid = 1'b0;
        check("ovf_err_sticky", 32'(load_err), 32'd1);
        check("ovf_ready_stays0", 32'(rx_ready), 32'd0);
        check("ovf_cpu_rst_stays", 32'(cpu_rst), 32'd1);
        check("ovf_done0", 32'(load_done), 32'd0);
        check("ovf_no_write", 32'(wr_cnt - base), 32'd0);

        // N=2 with random idle gaps
        do_reset();
        base = wr_cnt;
        send_len(32'd2);
        for (int i = 0; i < 8; i++) send_gap(pay_g[i]);
        end_image(8'h1C);
        expect_run("g");
        check("g_mem0", mem_model[0], 32'hA3A2A1A0);
        check("g_mem1", mem_model[1], 32'hA7A6A5A4);
        check("g_wr_count", 32'(wr_cnt - base), 32'd2);

        // Reset after 6 payload bytes, then a full N=1 image
        do_reset();
        send_len(32'd3);
        for (int i = 0; i < 6; i++) send_byte(8'hC0 + 8'(i));
        check("mid_cpu_rst", 32'(cpu_rst), 32'd1);
        check("mid_mem0", mem_model[0], 32'hC3C2C1C0);
        do_reset();
        check("mid_cpu_rst_after", 32'(cpu_rst), 32'd1);
        base = wr_cnt;
        send_len(32'd1);
        send_byte(8'hD0);
        send_byte(8'hD1);
        send_byte(8'hD2);
        send_byte(8'hD3);
        check("mid_waddr", 32'(imem_waddr), 32'd0);
        check("mid_wdata", imem_wdata, 32'hD3D2D1D0);
        end_image(8'h46);
        expect_run("mid");
        check("mid_mem0_new", mem_model[0], 32'hD3D2D1D0);
        check("mid_wr_count", 32'(wr_cnt - base), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match
        do_reset();
        send_len(32'd1);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        check("cs_ready", 32'(rx_ready), 32'd1);
        send_byte(8'h0A);
        expect_run("cs_ok");
        // Checksum mismatch
        do_reset();
        send_len(32'd1);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        send_byte(8'h0B);
        check("cs_bad_ready0", 32'(rx_ready), 32'd0);
        tick();
        check("cs_bad_err", 32'(load_err), 32'd1);
        check("cs_bad_cpu_rst", 32'(cpu_rst), 32'd1);
        check("cs_bad_done0", 32'(load_done), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
